cross_bar_resp_core: RTL and testbench

- Response-direction crossbar for the mcash banks.
- Each of the 4 bank HTUs returns responses tagged with the originating channel id. This block steers each response back to the matching request channel (3 channels).
- Each channel has its own round-robin arbiter across banks and a one-entry output register, so per-channel valid/ready handshakes are fully pipelined.
- Sits between the bank HTU response ports and the mcash channel response ports. It mirrors the request crossbar.

---
 rtl/mcash_pkg.sv | 31 +++
 rtl/xbar_resp_ch_port.sv | 91 +++++++++
 rtl/cross_bar_resp_core.sv | 88 ++++++++
 tb/tb_cross_bar_resp_core.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mcash_pkg.sv
// Shared mcash definitions: crossbar geometry, response header layout, opcodes
// and the round-robin pointer helper used by the response crossbar.
package mcash_pkg;

    localparam int NUM_BANKS = 4;
    localparam int NUM_CH    = 3;
    localparam int CHW       = 2;
    localparam int BIDW      = 2;
    localparam int AW        = 28;
    localparam int OPW       = 2;

    // Response opcodes echo the request opcode encoding.
    typedef enum logic [OPW-1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FLUSH = 2'b10,
        OP_INVAL = 2'b11
    } mcash_op_e;

    typedef struct packed {
        logic [BIDW-1:0] bank_id;
        logic [OPW-1:0]  opcode;
        logic [AW-1:0]   addr;
    } resp_hdr_t;

    // Priority pointer moves to the bank after the one just served.
    function automatic logic [BIDW-1:0] rr_next(input logic [BIDW-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/xbar_resp_ch_port.sv
// One response channel: round-robin pick among requesting banks, payload mux
// and a single-entry output register with a fully pipelined valid/ready.
module xbar_resp_ch_port
    import mcash_pkg::*;
#(
    parameter int NB = NUM_BANKS,
    parameter int DW = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NB-1:0]    req_i,
    input  logic [OPW*NB-1:0] opcode_i,
    input  logic [AW*NB-1:0] addr_i,
    input  logic [DW*NB-1:0] data_i,
    input  logic             ready_i,
    output logic [NB-1:0]    grant_o,
    output logic             valid_o,
    output logic [BIDW-1:0]  bank_id_o,
    output logic [OPW-1:0]   opcode_o,
    output logic [AW-1:0]    addr_o,
    output logic [DW-1:0]    data_o
);

    logic [BIDW-1:0] ptr_q, ptr_d;
    logic [BIDW-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_load;
    logic            load;
    logic            valid_q, valid_d;
    resp_hdr_t       hdr_q, hdr_d;
    logic [DW-1:0]   data_q, data_d;

    // Scan from the far end so the bank nearest the pointer wins last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_q) + i) % NB]) begin
                gnt_any = 1'b1;
                gnt_idx = BIDW'((int'(ptr_q) + i) % NB);
            end
        end
    end

    assign can_load = !valid_q || ready_i;
    assign load     = gnt_any && can_load;

    always_comb begin
        grant_o = '0;
        if (load) begin
            grant_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = load ? rr_next(gnt_idx, NB) : ptr_q;
        valid_d = valid_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        if (load) begin
            valid_d       = 1'b1;
            hdr_d.bank_id = gnt_idx;
            hdr_d.opcode  = opcode_i[int'(gnt_idx)*OPW +: OPW];
            hdr_d.addr    = addr_i[int'(gnt_idx)*AW +: AW];
            data_d        = data_i[int'(gnt_idx)*DW +: DW];
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            hdr_q   <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o   = valid_q;
    assign bank_id_o = hdr_q.bank_id;
    assign opcode_o  = hdr_q.opcode;
    assign addr_o    = hdr_q.addr;
    assign data_o    = data_q;

endmodule

// File: rtl/cross_bar_resp_core.sv
// Response crossbar: steers bank HTU responses back to their originating
// mcash channel, one independent arbiter/output register per channel.
module cross_bar_resp_core
    import mcash_pkg::*;
#(
    parameter int NB = NUM_BANKS,
    parameter int NC = NUM_CH,
    parameter int DW = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB-1:0]     bank_xbar_resp_valid_i,
    output logic [NB-1:0]     bank_xbar_resp_ready_o,
    input  logic [CHW*NB-1:0] bank_xbar_resp_ch_id_i,
    input  logic [OPW*NB-1:0] bank_xbar_resp_opcode_i,
    input  logic [AW*NB-1:0]  bank_xbar_resp_addr_i,
    input  logic [DW*NB-1:0]  bank_xbar_resp_data_i,
    output logic [NC-1:0]     mcash_ch_resp_valid_o,
    input  logic [NC-1:0]     mcash_ch_resp_ready_i,
    output logic [BIDW*NC-1:0] mcash_ch_resp_bank_id_o,
    output logic [OPW*NC-1:0] mcash_ch_resp_opcode_o,
    output logic [AW*NC-1:0]  mcash_ch_resp_addr_o,
    output logic [DW*NC-1:0]  mcash_ch_resp_data_o,
    output logic              xbar_resp_err_o
);

    logic [NB-1:0] req [NC];
    logic [NB-1:0] gnt [NC];
    logic          bad_any;
    logic          err_q, err_d;

    always_comb begin
        bad_any = 1'b0;
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < NB; b++) begin
                req[c][b] = bank_xbar_resp_valid_i[b] &&
                            (bank_xbar_resp_ch_id_i[b*CHW +: CHW] == CHW'(c));
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (bank_xbar_resp_valid_i[b] && int'(bank_xbar_resp_ch_id_i[b*CHW +: CHW]) >= NC) begin
                bad_any = 1'b1;
            end
        end
    end

    // A bank targets one channel, so at most one grant term is ever set per bank.
    always_comb begin
        bank_xbar_resp_ready_o = '0;
        for (int c = 0; c < NC; c++) begin
            bank_xbar_resp_ready_o = bank_xbar_resp_ready_o | gnt[c];
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_ch
        xbar_resp_ch_port #(
            .NB (NB),
            .DW (DW)
        ) u_port (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (req[c]),
            .opcode_i  (bank_xbar_resp_opcode_i),
            .addr_i    (bank_xbar_resp_addr_i),
            .data_i    (bank_xbar_resp_data_i),
            .ready_i   (mcash_ch_resp_ready_i[c]),
            .grant_o   (gnt[c]),
            .valid_o   (mcash_ch_resp_valid_o[c]),
            .bank_id_o (mcash_ch_resp_bank_id_o[c*BIDW +: BIDW]),
            .opcode_o  (mcash_ch_resp_opcode_o[c*OPW +: OPW]),
            .addr_o    (mcash_ch_resp_addr_o[c*AW +: AW]),
            .data_o    (mcash_ch_resp_data_o[c*DW +: DW])
        );
    end

    assign err_d = err_q | bad_any;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign xbar_resp_err_o = err_q;

endmodule

// File: tb/tb_cross_bar_resp_core.sv
// Directed bench for the response crossbar: vector table plus hand sequences
// for back-pressure, invalid channel id and asynchronous reset.
module tb_cross_bar_resp_core;

    localparam int NB = 4;
    localparam int NC = 3;
    localparam int DW = 128;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [NB-1:0]   bank_valid = '0;
    logic [NB-1:0]   bank_ready;
    logic [2*NB-1:0] bank_ch_id = '0;
    logic [2*NB-1:0] bank_opcode;
    logic [28*NB-1:0] bank_addr;
    logic [DW*NB-1:0] bank_data;
    logic [NC-1:0]   ch_valid;
    logic [NC-1:0]   ch_ready = '1;
    logic [2*NC-1:0] ch_bank_id;
    logic [2*NC-1:0] ch_opcode;
    logic [28*NC-1:0] ch_addr;
    logic [DW*NC-1:0] ch_data;
    logic            err;

    logic [1:0]    op [NB];
    logic [27:0]   ad [NB];
    logic [DW-1:0] dt [NB];
    logic          exp_err = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] vld;
        logic [7:0] chid;
        logic [2:0] rdy;
        logic [3:0] exp_brdy;
        logic [2:0] exp_vld;
        logic [5:0] exp_bid;
    } vec_t;

    vec_t tbl [10];

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_opcode[b*2 +: 2]   = op[b];
            bank_addr[b*28 +: 28]   = ad[b];
            bank_data[b*DW +: DW]   = dt[b];
        end
    end

    cross_bar_resp_core #(.NB(NB), .NC(NC), .DW(DW)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .bank_xbar_resp_valid_i  (bank_valid),
        .bank_xbar_resp_ready_o  (bank_ready),
        .bank_xbar_resp_ch_id_i  (bank_ch_id),
        .bank_xbar_resp_opcode_i (bank_opcode),
        .bank_xbar_resp_addr_i   (bank_addr),
        .bank_xbar_resp_data_i   (bank_data),
        .mcash_ch_resp_valid_o   (ch_valid),
        .mcash_ch_resp_ready_i   (ch_ready),
        .mcash_ch_resp_bank_id_o (ch_bank_id),
        .mcash_ch_resp_opcode_o  (ch_opcode),
        .mcash_ch_resp_addr_o    (ch_addr),
        .mcash_ch_resp_data_o    (ch_data),
        .xbar_resp_err_o         (err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of bank/channel inputs, check same-cycle bank ready,
    // then check the channel registers and error flag after the clock edge.
    task automatic apply(input string tag, input logic [3:0] v, input logic [7:0] ch,
                         input logic [2:0] r, input logic [3:0] eb,
                         input logic [2:0] ev, input logic [5:0] ebid);
        logic [1:0] bid;
        bank_valid = v;
        bank_ch_id = ch;
        ch_ready   = r;
        #1;
        check({tag, " bank_ready"}, 128'(bank_ready), 128'(eb));
        @(posedge clk_i);
        #1;
        check({tag, " ch_valid"}, 128'(ch_valid), 128'(ev));
        check({tag, " err"}, 128'(err), 128'(exp_err));
        for (int c = 0; c < NC; c++) begin
            if (ev[c]) begin
                bid = ebid[c*2 +: 2];
                check($sformatf("%s ch%0d bank_id", tag, c), 128'(ch_bank_id[c*2 +: 2]), 128'(bid));
                check($sformatf("%s ch%0d opcode", tag, c), 128'(ch_opcode[c*2 +: 2]), 128'(op[bid]));
                check($sformatf("%s ch%0d addr", tag, c), 128'(ch_addr[c*28 +: 28]), 128'(ad[bid]));
                check($sformatf("%s ch%0d data", tag, c), ch_data[c*DW +: DW], dt[bid]);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            op[b] = 2'(b);
            ad[b] = 28'h1234565 + 28'(b);
            dt[b] = {16{8'hA3 + 8'(b)}};
        end

        //              vld      chid          rdy     brdy     vld     bank ids {ch2,ch1,ch0}
        tbl[0] = '{4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00};
        tbl[1] = '{4'b0100, 8'b00_01_00_00, 3'b111, 4'b0100, 3'b010, 6'b00_10_00};
        tbl[2] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b0001, 3'b001, 6'b00_00_00};
        tbl[3] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b0010, 3'b001, 6'b00_00_01};
        tbl[4] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b1000, 3'b001, 6'b00_00_11};
        tbl[5] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b0001, 3'b001, 6'b00_00_00};
        tbl[6] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b0010, 3'b001, 6'b00_00_01};
        tbl[7] = '{4'b1011, 8'b00_00_00_00, 3'b111, 4'b1000, 3'b001, 6'b00_00_11};
        tbl[8] = '{4'b0111, 8'b00_01_00_10, 3'b111, 4'b0111, 3'b111, 6'b00_10_01};
        tbl[9] = '{4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00};

        repeat (2) @(posedge clk_i);
        #1;
        check("reset ch_valid", 128'(ch_valid), 128'(0));
        check("reset err", 128'(err), 128'(0));
        check("reset ch_data", ch_data[DW-1:0], 128'(0));
        check("reset ch_addr", 128'(ch_addr), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].vld, tbl[i].chid, tbl[i].rdy,
                  tbl[i].exp_brdy, tbl[i].exp_vld, tbl[i].exp_bid);
        end

        // Back-pressure on ch2: held entry must not be overwritten until ready returns.
        apply("bp_load", 4'b0001, 8'b00_00_00_10, 3'b011, 4'b0001, 3'b100, 6'b00_00_00);
        ad[1] = 28'hFEDCBA9;
        dt[1] = {4{32'h5A5A_C3C3}};
        apply("bp_hold0", 4'b0010, 8'b00_00_10_00, 3'b011, 4'b0000, 3'b100, 6'b00_00_00);
        apply("bp_hold1", 4'b0010, 8'b00_00_10_00, 3'b011, 4'b0000, 3'b100, 6'b00_00_00);
        apply("bp_swap", 4'b0010, 8'b00_00_10_00, 3'b111, 4'b0010, 3'b100, 6'b01_00_00);
        apply("bp_drain", 4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00);

        // Reserved channel id: never accepted, error flag sticks.
        exp_err = 1'b1;
        apply("err_set", 4'b1000, 8'b11_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00);
        apply("err_hold", 4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00);

        // Asynchronous reset while ch0 holds a response.
        apply("pre_rst", 4'b0001, 8'b00_00_00_00, 3'b110, 4'b0001, 3'b001, 6'b00_00_00);
        bank_valid = '0;
        #3;
        rst_i = 1'b0;
        #1;
        check("async_rst ch_valid", 128'(ch_valid), 128'(0));
        check("async_rst err", 128'(err), 128'(0));
        exp_err = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        apply("post_rst0", 4'b1011, 8'b00_00_00_00, 3'b111, 4'b0001, 3'b001, 6'b00_00_00);
        apply("post_rst1", 4'b1011, 8'b00_00_00_00, 3'b111, 4'b0010, 3'b001, 6'b00_00_01);
        apply("post_rst2", 4'b1011, 8'b00_00_00_00, 3'b111, 4'b1000, 3'b001, 6'b00_00_11);
        apply("idle_end", 4'b0000, 8'b00_00_00_00, 3'b111, 4'b0000, 3'b000, 6'b00_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
